// File: rtl/nv_mux2_rr_arb.sv
// Purpose: two-requester round-robin packet arbiter with packet-level grant lock and a registered 2:1 output stage.
// Latency: a beat accepted at a rising edge is presented on out_* right after that same edge (one cycle after input handshake).
// Backpressure: out_valid high with out_ready low drops both input readies; output, lock state and round-robin pointer freeze.
module nv_mux2_rr_arb #(
    parameter int DW = 32
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,

    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW-1:0] in0_pd,
    input  logic          in0_last,

    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [DW-1:0] in1_pd,
    input  logic          in1_last,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pd,
    output logic          out_last,
    output logic          out_src,

    output logic          arb_sel,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    // Registered state and its next-state values.
    state_t          state_q,     state_d;
    logic            rr_last_q,   rr_last_d;
    logic            out_vld_q,   out_vld_d;
    logic [DW-1:0]   out_pd_q,    out_pd_d;
    logic            out_last_q,  out_last_d;
    logic            out_src_q,   out_src_d;

    // Arbitration results for the current cycle.
    logic            grant_vld;
    logic            grant_idx;
    logic            sel_valid;
    logic [DW-1:0]   sel_pd;
    logic            sel_last;
    logic            can_load;
    logic            load;

    // Pick the winner: lock holder wins unconditionally, otherwise round-robin on ties.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_last_q;
        case (state_q)
            ST_LOCK0: begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end
            ST_LOCK1: begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
            default: begin
                if (in0_valid && in1_valid) begin
                    grant_vld = 1'b1;
                    grant_idx = ~rr_last_q;
                end else if (in0_valid) begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b0;
                end else if (in1_valid) begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b1;
                end
            end
        endcase
    end

    // Steer the granted requester through the 2:1 mux and derive handshakes.
    always_comb begin
        sel_valid = grant_idx ? in1_valid : in0_valid;
        sel_pd    = grant_idx ? in1_pd    : in0_pd;
        sel_last  = grant_idx ? in1_last  : in0_last;
        // The output stage can take a beat when empty or draining this edge.
        can_load  = !out_vld_q || out_ready;
        // Readies are masked during reset so nothing is accepted and then lost.
        in0_ready = grant_vld && !grant_idx && can_load && !nvdla_core_rst;
        in1_ready = grant_vld &&  grant_idx && can_load && !nvdla_core_rst;
        load      = grant_vld && sel_valid && can_load && !nvdla_core_rst;
    end

    // Next-state: load the output stage, track packet lock, update pointer on last beats.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        out_vld_d  = out_vld_q;
        out_pd_d   = out_pd_q;
        out_last_d = out_last_q;
        out_src_d  = out_src_q;
        if (load) begin
            out_vld_d  = 1'b1;
            out_pd_d   = sel_pd;
            out_last_d = sel_last;
            out_src_d  = grant_idx;
            if (sel_last) begin
                state_d   = ST_IDLE;
                rr_last_d = grant_idx;
            end else begin
                state_d   = grant_idx ? ST_LOCK1 : ST_LOCK0;
            end
        end else if (out_ready) begin
            // Stale payload is kept; only the valid flag drops.
            out_vld_d = 1'b0;
        end
    end

    // State register with synchronous reset; rr_last resets to 1 so in0 wins the first tie.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= 1'b1;
            out_vld_q  <= 1'b0;
            out_pd_q   <= '0;
            out_last_q <= 1'b0;
            out_src_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            out_vld_q  <= out_vld_d;
            out_pd_q   <= out_pd_d;
            out_last_q <= out_last_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_pd    = out_pd_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    // With no grant grant_idx already defaults to rr_last_q.
    assign arb_sel   = grant_idx;
    assign busy      = (state_q != ST_IDLE);

    // The two requesters can never be handed a ready in the same cycle.
    a_one_ready: assert property (@(posedge nvdla_core_clk) !(in0_ready && in1_ready));

    // A stalled output beat must not change underneath the downstream consumer.
    a_out_stable: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_pd) && $stable(out_last) && $stable(out_src)));

endmodule

// File: doc/nv_mux2_rr_arb.md
# nv_mux2_rr_arb

Two-requester round-robin packet arbiter that shares one downstream channel between two valid/ready sources and drives the 2:1 mux select that steers the data. Grant is held for the whole packet, delimited by a `last` flag. The granted beat is registered in a single-entry output stage. It sits in front of any shared NVDLA datapath port fed by two producers, for example two DMA read clients sharing one request channel.

## Interface
- `DW`, default 32, payload width per beat.
- `nvdla_core_clk`  in  1  core clock; all state updates on the rising edge.
- `nvdla_core_rst`  in  1  synchronous, active-high reset.
- `in0_valid`  in  1  requester 0 beat valid.
- `in0_ready`  out  1  requester 0 beat accepted this cycle when `in0_valid` is also high.
- `in0_pd`  in  DW  requester 0 payload.
- `in0_last`  in  1  requester 0 final beat of packet.
- `in1_valid` / `in1_ready` / `in1_pd` / `in1_last`: same as requester 0, for requester 1.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_pd`  out  DW  registered payload.
- `out_last`  out  1  registered last flag.
- `out_src`  out  1  source index of the registered beat.
- `arb_sel`  out  1  current mux select (0 = in0, 1 = in1).
- `busy`  out  1  high in LOCK0 or LOCK1.

## Operation
- States:
  - IDLE: no packet in flight.
  - LOCK0: packet from in0 open.
  - LOCK1: packet from in1 open.
- Round-robin pointer `rr_last` records the last winner.
- Stage-free condition: `can_load = !out_valid || out_ready`.
- Grant in IDLE, combinational with no bubble cycle:
  - only one `inN_valid` high: that requester wins;
  - both high: the requester != `rr_last` wins;
  - neither high: no grant, and `arb_sel` holds `rr_last`.
- Grant in LOCKn: always requester n. The other requester's valid is ignored.
- `inN_ready = grant_n && can_load`. At most one ready is high in any cycle.
- An accepted beat loads `out_pd`, `out_last` and `out_src` from the granted requester, and sets `out_valid`.
- State transitions on an accepted beat from requester n:
  - `last` = 0: go to (or stay in) LOCKn.
  - `last` = 1: go to IDLE and set `rr_last` = n.
- A single-beat packet accepted in IDLE stays in IDLE and updates `rr_last`.
- `rr_last` updates only on acceptance of a last beat.
- `arb_sel`:
  - equals the grant index whenever a grant exists;
  - in LOCKn equals n even while `inN_valid` is low;
  - in IDLE with no request equals `rr_last`.
- `busy` = (state != IDLE).

## Timing
- Reset values, applied synchronously on the edge where `nvdla_core_rst` = 1:
  - `out_valid` = 0, `out_pd` = 0, `out_last` = 0, `out_src` = 0;
  - state = IDLE;
  - `rr_last` = 1, so in0 wins the first tie;
  - `arb_sel` = 1 and `busy` = 0 immediately after reset.
- While `nvdla_core_rst` is high, `in0_ready` and `in1_ready` are 0.
- Latency: a beat accepted at edge k is visible on `out_*` at edge k (registered). It is presented to downstream one cycle after input acceptance.
- Throughput: 1 beat/cycle with `out_ready` held high. Packets switch back-to-back with no idle cycle.
- Backpressure: `out_valid` = 1 and `out_ready` = 0 drives both readies to 0. `out_*` holds stable, and state and `rr_last` are frozen.
- Simultaneous output accept and new load: the register is overwritten and `out_valid` stays 1.
- `out_ready` = 1 with no load: `out_valid` goes to 0 at the next edge. `out_pd` keeps its stale value.
- Lock holder deasserts valid mid-packet: the state stays LOCKn, no beats transfer, and the other requester stays blocked indefinitely.
- Reset mid-packet: forced to IDLE, any partial packet is abandoned and `out_valid` = 0. A protocol-level packet drop is acceptable.
- Requester protocol: `inN_pd`/`inN_last` are held stable while valid is high and not ready. The block does not check this.

## Test plan
- Reset, then `in0_valid` = `in1_valid` = 1 with 1-beat packets (`pd` = 0xA0 / 0xB1), `out_ready` = 1 -> outputs alternate 0xA0 (src 0), 0xB1, 0xA0, 0xB1 on consecutive cycles; first beat on `out_*` one cycle after acceptance.
- in0 sends a 4-beat packet 0x10..0x13 (last on 0x13) while in1 is valid from cycle 1 -> `out_pd` = 0x10, 0x11, 0x12, 0x13, then in1's beat. `in1_ready` = 0 and `busy` = 1 throughout the in0 packet.
- `out_ready` held 0 for 3 cycles mid-packet -> `out_pd` stable, both readies 0, `arb_sel` unchanged. On release, the next beat appears with no loss or duplication.
- in1 opens a packet (2 beats, last not yet sent), then drops valid for 2 cycles while in0 is valid -> `arb_sel` = 1, `in0_ready` = 0. in1 resumes with last -> IDLE, and in0 is granted the next cycle.
- Assert `nvdla_core_rst` for 1 cycle during LOCK0 with `out_valid` = 1 -> next cycle `out_valid` = 0, `busy` = 0, `arb_sel` = 1. A subsequent tie is won by in0.
- Only in1 requesting, 8 single-beat packets, `out_ready` = 1 -> 8 consecutive beats, all `out_src` = 1, no bubbles.
